// File: rtl/sm_prog_loader_if.sv
// rtl/sm_prog_loader_if.sv - byte-stream and instruction-memory write bundle for sm_prog_loader
//
// Purpose: groups the host byte handshake and the imem write port.
//   master : host side, drives byte_valid/byte_data, observes the rest
//   slave  : loader side, accepts bytes and drives the imem write port
// Signals:
//   byte_valid, byte_data[7:0]  host byte offer
//   byte_ready                  loader can take the byte this cycle
//   imem_we                     one-cycle write strobe per assembled word
//   imem_addr[ADDR_WIDTH-1:0]   word address
//   imem_wdata[31:0]            little-endian assembled word
interface sm_prog_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/sm_prog_loader.sv
// rtl/sm_prog_loader.sv - byte-stream program loader for the sm_cpu instruction memory
//
// Purpose: takes a length byte followed by little-endian instruction bytes, writes the
// assembled 32-bit words into instruction memory and keeps the CPU in reset while loading
// and for RESET_HOLD cycles afterwards.
// Optional feature macro: SM_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte,
// the CSUM/ERR states and the sticky error output; when undefined error is tied 0).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load_req     single-cycle pulse requesting a new load (honoured in RUN and ERR)
//   bus          sm_prog_loader_if.slave: byte handshake in, imem write port out
//   cpu_rst_n    active-low reset to sm_cpu, high only in RUN
//   busy         high while holding, loading or waiting for the checksum
//   error        sticky checksum mismatch flag
module sm_prog_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int RESET_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_req,
    sm_prog_loader_if.slave bus,
    output logic            cpu_rst_n,
    output logic            busy,
    output logic            error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int HW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

`ifdef SM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HOLD, S_RUN, S_LEN, S_DATA, S_CSUM, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_HOLD, S_RUN, S_LEN, S_DATA} state_t;
`endif

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
    logic                  last_pend_q, last_pend_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  busy_q, busy_d;
`ifdef SM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  error_q, error_d;
`endif

    logic                  accept;
    logic [ADDR_WIDTH-1:0] len_last;

    // byte_ready is registered, so a transfer is simply valid against the current flop.
    assign accept = bus.byte_valid && byte_ready_q;

    // Length byte to last word index; 0 and oversize lengths both mean a full memory.
    always_comb begin
        len_last = ADDR_WIDTH'(DEPTH - 1);
        if (bus.byte_data != 8'd0 && 32'(bus.byte_data) <= 32'(DEPTH)) begin
            len_last = ADDR_WIDTH'(32'(bus.byte_data) - 32'd1);
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_idx_d   = word_idx_q;
        last_idx_d   = last_idx_q;
        last_pend_d  = last_pend_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef SM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                if (load_req) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    last_idx_d  = len_last;
                    word_idx_d  = '0;
                    byte_cnt_d  = 2'd0;
                    last_pend_d = 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
                    csum_d      = 8'd0;
`endif
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (last_pend_q) begin
                    // The final word's write cycle has just completed.
                    last_pend_d = 1'b0;
`ifdef SM_LOADER_CHECKSUM_EN
                    state_d     = S_CSUM;
`else
                    state_d     = S_HOLD;
                    hold_cnt_d  = '0;
`endif
                end else if (accept) begin
                    // Shift right so the first byte received ends up in bits [7:0].
                    shift_d    = {bus.byte_data, shift_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef SM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {bus.byte_data, shift_q};
                        imem_addr_d  = word_idx_q;
                        if (word_idx_q == last_idx_q) begin
                            // Stay in DATA for the write cycle; index is not advanced so it cannot wrap.
                            last_pend_d = 1'b1;
                        end else begin
                            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
`ifdef SM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    hold_cnt_d = '0;
                    state_d    = (bus.byte_data == csum_q) ? S_HOLD : S_ERR;
                end
            end
            S_ERR: begin
                if (load_req) begin
                    state_d = S_LEN;
                end
            end
`endif
            default: begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
            end
        endcase

        // All status outputs are registered from the next state.
        cpu_rst_n_d  = (state_d == S_RUN);
        busy_d       = (state_d != S_RUN);
        byte_ready_d = (state_d == S_LEN) || ((state_d == S_DATA) && !last_pend_d);
`ifdef SM_LOADER_CHECKSUM_EN
        if (state_d == S_ERR) begin
            busy_d = 1'b0;
        end
        if (state_d == S_CSUM) begin
            byte_ready_d = 1'b1;
        end
        error_d = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= '0;
            word_idx_q   <= '0;
            last_idx_q   <= '0;
            last_pend_q  <= 1'b0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b1;
`ifdef SM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_idx_q   <= word_idx_d;
            last_idx_q   <= last_idx_d;
            last_pend_q  <= last_pend_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            busy_q       <= busy_d;
`ifdef SM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            error_q      <= error_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_rst_n      = cpu_rst_n_q;
    assign busy           = busy_q;
`ifdef SM_LOADER_CHECKSUM_EN
    assign error          = error_q;
`else
    assign error          = 1'b0;
`endif
endmodule

// File: tb/tb_sm_prog_loader.sv
// tb/tb_sm_prog_loader.sv - directed self-checking bench for sm_prog_loader
`timescale 1ns/1ps
module tb_sm_prog_loader;
    localparam int AW = 6;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic load_req = 1'b0;
    logic cpu_rst_n;
    logic busy;
    logic error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int            wr_total = 0;
    logic [AW-1:0] wr_addr_log [0:255];
    logic [31:0]   wr_data_log [0:255];

    sm_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

    sm_prog_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_req  (load_req),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (wr_total < 256) begin
                wr_addr_log[wr_total] = bus.imem_addr;
                wr_data_log[wr_total] = bus.imem_wdata;
            end
            wr_total = wr_total + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total_cnt++;
            $display("FAIL send_byte_timeout byte=%02h got no byte_ready within 200 cycles", b);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    // Counts mid-cycle samples with cpu_rst_n low until it rises; ends at posedge+1.
    task automatic wait_run(output int low_cnt, output bit ok);
        low_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_rst_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
            low_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // After the last data byte: send the checksum if the feature exists, else step into HOLD.
    task automatic finish_load(input logic [7:0] csum);
`ifdef SM_LOADER_CHECKSUM_EN
        send_byte(csum);
`else
        if (csum === 8'hxx) $display("unused");
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset;
        int low;
        bit ok;
        int start;
        rst_n = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL reset_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL reset_byte_ready got %b want 0", bus.byte_ready); else pass_cnt++;
        total_cnt++; if (bus.imem_we !== 1'b0) $display("FAIL reset_imem_we got %b want 0", bus.imem_we); else pass_cnt++;
        total_cnt++; if (bus.imem_addr !== 6'd0) $display("FAIL reset_imem_addr got %0d want 0", bus.imem_addr); else pass_cnt++;
        total_cnt++; if (bus.imem_wdata !== 32'h0) $display("FAIL reset_imem_wdata got %08h want 0", bus.imem_wdata); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = wr_total;
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL reset_hold_cycles got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL run_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL run_byte_ready got %b want 0", bus.byte_ready); else pass_cnt++;
        total_cnt++; if (wr_total != start) $display("FAIL reset_no_write got %0d writes want 0", wr_total - start); else pass_cnt++;
    endtask

    task automatic test_basic_load;
        int low;
        bit ok;
        int start;
        start = wr_total;
        pulse_load();
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL load_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL load_busy got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL len_byte_ready got %b want 1", bus.byte_ready); else pass_cnt++;
        send_byte(8'h02);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        total_cnt++; if (bus.imem_we !== 1'b1) $display("FAIL last_write_we got %b want 1", bus.imem_we); else pass_cnt++;
        total_cnt++; if (bus.imem_addr !== 6'd1) $display("FAIL last_write_addr got %0d want 1", bus.imem_addr); else pass_cnt++;
        total_cnt++; if (bus.imem_wdata !== 32'hDEADBEEF) $display("FAIL last_write_data got %08h want deadbeef", bus.imem_wdata); else pass_cnt++;
        finish_load(8'h2A);
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL basic_hold_cycles got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (wr_total - start != 2) $display("FAIL basic_write_count got %0d want 2", wr_total - start); else pass_cnt++;
        total_cnt++; if (wr_addr_log[start] !== 6'd0 || wr_data_log[start] !== 32'h12345678)
            $display("FAIL basic_word0 got %0d:%08h want 0:12345678", wr_addr_log[start], wr_data_log[start]); else pass_cnt++;
        total_cnt++; if (wr_addr_log[start+1] !== 6'd1 || wr_data_log[start+1] !== 32'hDEADBEEF)
            $display("FAIL basic_word1 got %0d:%08h want 1:deadbeef", wr_addr_log[start+1], wr_data_log[start+1]); else pass_cnt++;
    endtask

    task automatic test_back_pressure;
        logic [31:0] exp_w [0:3];
        int low;
        bit ok;
        int start;
        int gap;
        exp_w[0] = 32'h04030201;
        exp_w[1] = 32'h08070605;
        exp_w[2] = 32'h0C0B0A09;
        exp_w[3] = 32'h100F0E0D;
        start = wr_total;
        pulse_load();
        send_byte(8'h04);
        for (int i = 1; i <= 16; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            if (i == 7) pulse_load();
            send_byte(8'(i));
        end
        finish_load(8'h10);
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL bp_hold_cycles got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (wr_total - start != 4) $display("FAIL bp_write_count got %0d want 4", wr_total - start); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (wr_addr_log[start+k] !== 6'(k) || wr_data_log[start+k] !== exp_w[k])
                $display("FAIL bp_word%0d got %0d:%08h want %0d:%08h", k, wr_addr_log[start+k], wr_data_log[start+k], k, exp_w[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_len_zero;
        logic [31:0] exp;
        int low;
        bit ok;
        int start;
        start = wr_total;
        pulse_load();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        finish_load(8'h00);
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL len0_hold_cycles got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (wr_total - start != 64) $display("FAIL len0_write_count got %0d want 64", wr_total - start); else pass_cnt++;
        for (int k = 0; k < 64; k++) begin
            exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            total_cnt++;
            if (wr_addr_log[start+k] !== 6'(k) || wr_data_log[start+k] !== exp)
                $display("FAIL len0_word%0d got %0d:%08h want %0d:%08h", k, wr_addr_log[start+k], wr_data_log[start+k], k, exp);
            else pass_cnt++;
        end
        total_cnt++; if (wr_addr_log[start+63] !== 6'd63 || wr_data_log[start+63] !== 32'hFFFEFDFC)
            $display("FAIL len0_last_word got %0d:%08h want 63:fffefdfc", wr_addr_log[start+63], wr_data_log[start+63]); else pass_cnt++;
    endtask

`ifdef SM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int low;
        bit ok;
        int start;
        start = wr_total;
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL csum_ok_hold got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL csum_ok_error got %b want 0", error); else pass_cnt++;
        total_cnt++; if (wr_data_log[start] !== 32'h44332211) $display("FAIL csum_ok_word got %08h want 44332211", wr_data_log[start]); else pass_cnt++;
        start = wr_total;
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        total_cnt++; if (error !== 1'b1) $display("FAIL csum_bad_error got %b want 1", error); else pass_cnt++;
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL csum_bad_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL csum_bad_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL csum_bad_ready got %b want 0", bus.byte_ready); else pass_cnt++;
        repeat (6) @(posedge clk);
        #1;
        total_cnt++; if (error !== 1'b1 || cpu_rst_n !== 1'b0) $display("FAIL csum_err_sticky got err=%b rst=%b want 1/0", error, cpu_rst_n); else pass_cnt++;
        total_cnt++; if (wr_total - start != 1) $display("FAIL csum_bad_written got %0d want 1", wr_total - start); else pass_cnt++;
        pulse_load();
        total_cnt++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL csum_reload_clear got err=%b busy=%b want 0/1", error, busy); else pass_cnt++;
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        wait_run(low, ok);
        total_cnt++; if (!ok || error !== 1'b0) $display("FAIL csum_reload_run got rose=%b err=%b want 1/0", ok, error); else pass_cnt++;
    endtask
`else
    task automatic test_error_tied;
        total_cnt++; if (error !== 1'b0) $display("FAIL error_tied got %b want 0", error); else pass_cnt++;
    endtask
`endif

    task automatic test_async_reset;
        int low;
        bit ok;
        int start;
        start = wr_total;
        pulse_load();
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL arst_cpu_rst_n got %b want 0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL arst_busy got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL arst_ready got %b want 0", bus.byte_ready); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_run(low, ok);
        total_cnt++; if (!ok || low != 4) $display("FAIL arst_hold got %0d (rose=%b) want 4", low, ok); else pass_cnt++;
        total_cnt++; if (wr_total != start) $display("FAIL arst_no_write got %0d want 0", wr_total - start); else pass_cnt++;
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_basic_load();
        test_back_pressure();
        test_len_zero();
`ifdef SM_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_error_tied();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
